// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: ID-stage hazard inputs and pipeline-control outputs.
// HAZARD_PERF_CNT_EN adds load_use_cnt / mem_wait_cnt.
interface hazard_stall_unit_if;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic        rs1_used_id;
  logic        rs2_used_id;
  logic [4:0]  rd_ex;
  logic        mem_read_ex;
  logic        branch_taken_ex;
  logic        dmem_req;
  logic        dmem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_write;
  logic        id_ex_flush;
  logic        ex_mem_write;
  logic        mem_wb_write;
  logic        stall;
  logic        mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] load_use_cnt;
  logic [31:0] mem_wait_cnt;
`endif

  modport master (
    output rs1_id,
    output rs2_id,
    output rs1_used_id,
    output rs2_used_id,
    output rd_ex,
    output mem_read_ex,
    output branch_taken_ex,
    output dmem_req,
    output dmem_ready,
    input  pc_write,
    input  if_id_write,
    input  if_id_flush,
    input  id_ex_write,
    input  id_ex_flush,
    input  ex_mem_write,
    input  mem_wb_write,
    input  stall,
    input  mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    input  load_use_cnt,
    input  mem_wait_cnt
`endif
  );

  modport slave (
    input  rs1_id,
    input  rs2_id,
    input  rs1_used_id,
    input  rs2_used_id,
    input  rd_ex,
    input  mem_read_ex,
    input  branch_taken_ex,
    input  dmem_req,
    input  dmem_ready,
    output pc_write,
    output if_id_write,
    output if_id_flush,
    output id_ex_write,
    output id_ex_flush,
    output ex_mem_write,
    output mem_wb_write,
    output stall,
    output mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output load_use_cnt,
    output mem_wait_cnt
`endif
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / branch / dmem-wait stall+flush control.
// Optional macro HAZARD_PERF_CNT_EN adds load-use and mem-wait counters.
module hazard_stall_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic               clk,
  input  logic               arst_n,
  hazard_stall_unit_if.slave hz
);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic             r_mem_err;
  logic             w_mem_err_nxt;

  logic w_mw;
  logic w_lu;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_bubble;
  logic w_freeze_wait;

  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_write;
  logic w_id_ex_flush;
  logic w_ex_mem_write;
  logic w_mem_wb_write;
  logic w_stall;

  assign w_mw = hz.dmem_req & ~hz.dmem_ready;

  assign w_rs1_hit = hz.rs1_used_id &
                     (hz.rd_ex == hz.rs1_id);
  assign w_rs2_hit = hz.rs2_used_id &
                     (hz.rd_ex == hz.rs2_id);
  assign w_lu = hz.mem_read_ex &
                (hz.rd_ex != 5'd0) &
                (w_rs1_hit | w_rs2_hit);

  // State, wait counter and sticky error register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= w_mem_err_nxt;
    end
  end

  // Next state and Mealy pipeline controls; release cycle acts like RUN.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_err_nxt  = r_mem_err;
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_write  = 1'b1;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_write = 1'b1;
    w_mem_wb_write = 1'b1;
    w_stall        = 1'b0;
    w_bubble       = 1'b0;
    w_freeze_wait  = 1'b0;
    unique case (r_state)
      S_RUN, S_MEM_WAIT: begin
        if (w_mw) begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_write  = 1'b0;
          w_ex_mem_write = 1'b0;
          w_mem_wb_write = 1'b0;
          w_stall        = 1'b1;
          w_freeze_wait  = 1'b1;
          if (r_state == S_RUN) begin
            w_state_nxt    = S_MEM_WAIT;
            w_wait_cnt_nxt = LP_ONE;
          end else if (r_wait_cnt == LP_LAST) begin
            w_state_nxt   = S_ERROR;
            w_mem_err_nxt = 1'b1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + LP_ONE;
          end
        end else begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
          if (hz.branch_taken_ex) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (w_lu) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
            w_stall       = 1'b1;
            w_bubble      = 1'b1;
          end
        end
      end
      S_ERROR: begin
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_id_ex_write  = 1'b0;
        w_ex_mem_write = 1'b0;
        w_mem_wb_write = 1'b0;
        w_stall        = 1'b1;
      end
      default: begin
        w_state_nxt    = S_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  assign hz.pc_write     = ~arst_n | w_pc_write;
  assign hz.if_id_write  = ~arst_n | w_if_id_write;
  assign hz.id_ex_write  = ~arst_n | w_id_ex_write;
  assign hz.ex_mem_write = ~arst_n | w_ex_mem_write;
  assign hz.mem_wb_write = ~arst_n | w_mem_wb_write;
  assign hz.if_id_flush  = arst_n & w_if_id_flush;
  assign hz.id_ex_flush  = arst_n & w_id_ex_flush;
  assign hz.stall        = arst_n & w_stall;
  assign hz.mem_err      = arst_n & r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_load_use_cnt;
  logic [31:0] r_mem_wait_cnt;

  // Free-running wrapping perf counters.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_load_use_cnt <= '0;
      r_mem_wait_cnt <= '0;
    end else begin
      if (w_bubble)
        r_load_use_cnt <= r_load_use_cnt + 32'd1;
      if (w_freeze_wait)
        r_mem_wait_cnt <= r_mem_wait_cnt + 32'd1;
    end
  end

  assign hz.load_use_cnt = r_load_use_cnt;
  assign hz.mem_wait_cnt = r_mem_wait_cnt;
`else
  logic w_unused;
  assign w_unused = w_bubble ^ w_freeze_wait;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench with a cycle-level reference model.
// Directed scenarios followed by randomized traffic and random resets.
module tb_hazard_stall_unit;

  localparam int TO = 4;

  typedef struct {
    logic [8:0]  v;
    logic [31:0] lc;
    logic [31:0] mc;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_unit_if hz();

  hazard_stall_unit #(
    .MEM_TIMEOUT(TO),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .hz(hz)
  );

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // model state: consecutive wait cycles, sticky error, perf counts
  int          m_waits = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_lc = '0;
  logic [31:0] m_mc = '0;

  // bit order: pc_w ifid_w ifid_f idex_w idex_f exmem_w memwb_w stall err
  localparam logic [8:0] E_NORM   = 9'b1_1_0_1_0_1_1_0_0;
  localparam logic [8:0] E_FLUSH  = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] E_BUBBLE = 9'b0_0_0_1_1_1_1_1_0;
  localparam logic [8:0] E_FREEZE = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] E_ERR    = 9'b0_0_0_0_0_0_0_1_1;

  task automatic do_reset(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    m_waits = 0;
    m_err = 1'b0;
    m_lc = '0;
    m_mc = '0;
    e.v = E_NORM;
    e.lc = '0;
    e.mc = '0;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drive(
    input string      tag,
    input logic [4:0] r1,
    input logic [4:0] r2,
    input logic       u1,
    input logic       u2,
    input logic [4:0] rd,
    input logic       mr,
    input logic       br,
    input logic       rq,
    input logic       rdy
  );
    exp_t e;
    bit mw;
    bit lu;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    hz.rs1_id = r1;
    hz.rs2_id = r2;
    hz.rs1_used_id = u1;
    hz.rs2_used_id = u2;
    hz.rd_ex = rd;
    hz.mem_read_ex = mr;
    hz.branch_taken_ex = br;
    hz.dmem_req = rq;
    hz.dmem_ready = rdy;
    mw = rq && !rdy;
    lu = mr && (rd != 0) &&
         ((u1 && rd == r1) || (u2 && rd == r2));
    e.tag = tag;
    e.lc = m_lc;
    e.mc = m_mc;
    if (m_err) begin
      e.v = E_ERR;
    end else if (mw) begin
      e.v = E_FREEZE;
      m_mc = m_mc + 1;
      m_waits++;
      if (m_waits == TO) m_err = 1'b1;
    end else begin
      m_waits = 0;
      if (br) begin
        e.v = E_FLUSH;
      end else if (lu) begin
        e.v = E_BUBBLE;
        m_lc = m_lc + 1;
      end else begin
        e.v = E_NORM;
      end
    end
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry per cycle, sampled at negedge.
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {hz.pc_write, hz.if_id_write,
               hz.if_id_flush, hz.id_ex_write,
               hz.id_ex_flush, hz.ex_mem_write,
               hz.mem_wb_write, hz.stall,
               hz.mem_err};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: got %b want %b",
                   e.tag, act, e.v);
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (hz.load_use_cnt !== e.lc ||
            hz.mem_wait_cnt !== e.mc) begin
          bad++;
          $display("FAIL %s_cnt: got %0d/%0d want %0d/%0d",
                   e.tag, hz.load_use_cnt,
                   hz.mem_wait_cnt, e.lc, e.mc);
        end
`endif
      end
    end
  end

  initial begin
    hz.rs1_id = '0;
    hz.rs2_id = '0;
    hz.rs1_used_id = 1'b0;
    hz.rs2_used_id = 1'b0;
    hz.rd_ex = '0;
    hz.mem_read_ex = 1'b0;
    hz.branch_taken_ex = 1'b0;
    hz.dmem_req = 1'b0;
    hz.dmem_ready = 1'b0;

    do_reset("rst0");
    do_reset("rst1");

    // load-use then natural release
    drive("lu", 5, 0, 1, 0, 5, 1, 0, 0, 0);
    drive("lu_rel", 5, 0, 1, 0, 0, 0, 0, 0, 0);
    drive("lu_rs2", 1, 9, 1, 1, 9, 1, 0, 0, 0);

    // x0 and unused operand
    drive("x0", 0, 3, 1, 0, 0, 1, 0, 0, 0);
    drive("unused", 2, 7, 1, 0, 7, 1, 0, 0, 0);
    drive("noload", 5, 0, 1, 0, 5, 0, 0, 0, 0);

    // branch beats load-use
    drive("br_lu", 5, 0, 1, 0, 5, 1, 1, 0, 0);
    drive("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // three-cycle wait then ready
    repeat (3)
      drive("mw", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive("mw_rdy", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // wait with branch held, flush only on release
    repeat (2)
      drive("mw_br", 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive("mw_br_rel", 0, 0, 0, 0, 0, 0, 1, 1, 1);
    // wait with load-use held, bubble on release via req drop
    drive("mw_lu", 4, 0, 1, 0, 4, 1, 0, 1, 0);
    drive("mw_lu_rel", 4, 0, 1, 0, 4, 1, 0, 0, 0);

    // timeout then sticky error
    repeat (6)
      drive("to", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2)
      drive("err_rdy", 5, 0, 1, 0, 5, 1, 1, 1, 1);
    do_reset("err_rst");
    drive("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // wait of exactly TO-1 cycles must not error
    repeat (TO - 1)
      drive("edge", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive("edge_rel", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("edge_ok", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset("r_rst");
      end else begin
        drive("rand",
              5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 2) == 0));
      end
    end

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0",
               sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Consumer-side companion to the EX-stage forwarding logic in the 5-stage RISC-V pipeline. It detects hazards that forwarding cannot resolve: load-use dependencies, taken-branch control hazards and multi-cycle data-memory accesses. It drives pipeline-register write enables and flushes, and runs a small FSM with a watchdog for memory waits. It sits in the ID stage next to the control unit.

Parameters:
- MEM_TIMEOUT, 16, maximum consecutive wait cycles on a data-memory access before the error state (must be ≥2).
- CNT_W, 5, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- rs1_id  in  5  rs1 of the instruction in ID
- rs2_id  in  5  rs2 of the instruction in ID
- rs1_used_id  in  1  ID instruction reads rs1
- rs2_used_id  in  1  ID instruction reads rs2
- rd_ex  in  5  destination register in EX
- mem_read_ex  in  1  EX instruction is a load
- branch_taken_ex  in  1  branch/jump resolved taken in EX
- dmem_req  in  1  MEM stage has an outstanding data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID register loads a NOP
- id_ex_write  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX register loads a bubble
- ex_mem_write  out  1  EX/MEM register enable
- mem_wb_write  out  1  MEM/WB register enable
- stall  out  1  any stall or freeze is active this cycle
- mem_err  out  1  sticky memory-timeout error

Behaviour:
- Reset: the reset is asynchronous and active-low on arst_n. State goes to RUN, wait_cnt to 0 and mem_err to 0.
- Output values while arst_n is low: all *_write = 1, all flushes = 0, stall = 0, mem_err = 0.
- States: RUN, MEM_WAIT, ERROR. State is registered. Outputs are a Mealy function of state and inputs, with zero-cycle latency.
- Memory wait condition `mw = dmem_req & ~dmem_ready`.
- Load-use condition `lu = mem_read_ex & (rd_ex != 0) & ((rs1_used_id & rd_ex == rs1_id) | (rs2_used_id & rd_ex == rs2_id))`.
- Priority, highest first: ERROR > mw > branch_taken_ex > lu.
- RUN, when mw: freeze. All *_write = 0, no flush, stall = 1. Next state MEM_WAIT, wait_cnt = 1.
- RUN, when branch_taken_ex and not mw: if_id_flush = 1 and id_ex_flush = 1, all writes = 1, stall = 0. Any lu is ignored because the ID instruction is squashed.
- RUN, when lu only: pc_write = 0, if_id_write = 0, id_ex_flush = 1, other writes = 1, stall = 1. Exactly one bubble is inserted. The next cycle holds rd_ex = 0 and releases naturally.
- MEM_WAIT, while mw: freeze as above and increment wait_cnt. When wait_cnt reaches MEM_TIMEOUT-1 and mw still holds, go to ERROR.
- MEM_WAIT, when dmem_ready = 1 or dmem_req drops: go back to RUN and clear wait_cnt. In the same cycle, outputs are computed as in RUN with mw = 0, so a held branch_taken_ex or lu takes effect in that release cycle.
- ERROR: all *_write = 0, no flush, stall = 1, mem_err = 1. The block stays in ERROR until reset.
- Branch-flush conditions are never latched. Frozen EX holds branch_taken_ex stable for the whole freeze.
- x0 is never a hazard source.
- Reset asserted mid-wait or in ERROR forces RUN immediately, asynchronously.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: adds output ports `load_use_cnt` (32 bits) and `mem_wait_cnt` (32 bits), both free-running and wrapping.
  - `load_use_cnt` increments on each cycle in which a load-use bubble is inserted.
  - `mem_wait_cnt` increments on each freeze cycle in MEM_WAIT or RUN; ERROR cycles are not counted.
  - Both reset to 0 asynchronously.
- Undefined: the ports and registers are absent and the rest of the behaviour is identical.

Test Plan:
- Load-use: mem_read_ex = 1, rd_ex = 5, rs1_id = 5, rs1_used_id = 1. Expect one cycle with pc_write = 0, if_id_write = 0, id_ex_flush = 1, stall = 1. Next cycle rd_ex = 0, so all writes = 1 and stall = 0.
- x0 / unused operand: rd_ex = 0 with rs1_id = 0 → no stall. rd_ex = 7 with rs2_id = 7 but rs2_used_id = 0 → no stall.
- Branch beats load-use: branch_taken_ex = 1 and lu true in the same cycle. Expect if_id_flush = 1, id_ex_flush = 1, pc_write = 1, stall = 0.
- Memory wait: dmem_req = 1 with dmem_ready low for 3 cycles, then high. Expect all writes = 0 for 3 cycles and state MEM_WAIT. On the ready cycle all writes = 1. With HAZARD_PERF_CNT_EN defined, mem_wait_cnt = 3.
- Wait with branch held: branch_taken_ex = 1 throughout a 2-cycle wait. No flush during the wait; if_id_flush and id_ex_flush both = 1 exactly in the ready cycle.
- Timeout and reset: dmem_req = 1 and dmem_ready = 0 held with MEM_TIMEOUT = 4. Expect mem_err = 1 from the 5th wait cycle on, and it stays set when dmem_ready later rises. Pulsing arst_n low clears mem_err and returns all writes to 1.
